flappy_game_ctrl: RTL and testbench

- Per-frame game sequencer that drives the `vga640x480` renderer: produces `bird_coord` (bird top row) and `pipe_pos` (pipe left column).
- Steps bird physics and pipe scrolling once per video frame, timed on the falling edge of the renderer's `vsync`.
- Detects collisions and runs the IDLE/PLAY/DEAD game flow from a single flap button; exports score and game-over status.

---
 rtl/flappy_game_ctrl_pkg.sv | 17 +
 rtl/flappy_game_ctrl_if.sv | 23 ++
 rtl/flappy_game_ctrl_edge_sync.sv | 35 +++
 rtl/flappy_game_ctrl.sv | 167 ++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_game_ctrl_pkg.sv
// Shared constants and state encoding for the flappy game sequencer.
package flappy_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int ROW_BITS = 10;
  localparam int COL_BITS = 9;
  localparam int VEL_BITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } game_state_e;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Game-side signal bundle: raw button/vsync in, bird/pipe/score status out.
interface flappy_game_ctrl_if;
  import flappy_pkg::*;

  logic                flap;
  logic                vsync;
  logic [ROW_BITS-1:0] bird_coord;
  logic [COL_BITS-1:0] pipe_pos;
  logic [7:0]          score;
  logic                game_over;
  logic [1:0]          state;

  modport master (
    input  flap, vsync,
    output bird_coord, pipe_pos, score, game_over, state
  );

  modport slave (
    output flap, vsync,
    input  bird_coord, pipe_pos, score, game_over, state
  );

endinterface

// File: rtl/flappy_game_ctrl_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus a one-cycle edge pulse.
module flappy_edge_sync #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  generate
    if (RISING) begin : g_rise
      assign edge_o = sync_q & ~prev_q;
    end else begin : g_fall
      assign edge_o = ~sync_q & prev_q;
    end
  endgenerate

endmodule

// File: rtl/flappy_game_ctrl.sv
// Per-frame flappy game sequencer: bird physics, pipe scroll, collision, IDLE/PLAY/DEAD.
// Define FLAPPY_SPEEDUP_EN to add +1 pipe column/frame per 8 points (max +4).
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int BIRD_X     = 100,
  parameter int BIRD_W     = 16,
  parameter int BIRD_H     = 16,
  parameter int BIRD_Y0    = 200,
  parameter int PIPE_W     = 40,
  parameter int PIPE_START = 480,
  parameter int GAP_TOP    = 160,
  parameter int GAP_BOT    = 300,
  parameter int GRAVITY    = 1,
  parameter int FLAP_V     = 8,
  parameter int MAX_FALL   = 10,
  parameter int PIPE_SPEED = 2,
  parameter int DEAD_HOLD  = 60
) (
  input  logic               dclk,
  input  logic               clr,
  flappy_game_ctrl_if.master game
);

  localparam int Y_MAX = SCREEN_H - BIRD_H;
  localparam logic signed [VEL_BITS-1:0] VEL_FLAP = VEL_BITS'(-FLAP_V);
  localparam logic signed [VEL_BITS-1:0] VEL_CAP  = VEL_BITS'(MAX_FALL);
  localparam logic signed [VEL_BITS-1:0] VEL_GRAV = VEL_BITS'(GRAVITY);

  game_state_e                state_q;
  logic [ROW_BITS-1:0]        bird_q;
  logic [COL_BITS-1:0]        pipe_q;
  logic [7:0]                 score_q;
  logic [7:0]                 hold_q;
  logic signed [VEL_BITS-1:0] vel_q;
  logic                       game_over_q;
  logic                       flap_pend_q;

  logic                       flap_rise;
  logic                       frame_tick;
  logic                       pend_eff;
  logic signed [VEL_BITS-1:0] vel_inc;
  logic signed [VEL_BITS-1:0] vel_d;
  logic signed [10:0]         y_sum;
  logic [ROW_BITS-1:0]        bird_d;
  logic                       ground_hit;
  logic [COL_BITS-1:0]        speed;
  logic [COL_BITS-1:0]        pipe_d;
  logic                       wrap;
  logic [7:0]                 score_d;
  logic [10:0]                pipe_ext;
  logic [10:0]                bird_ext;
  logic                       h_overlap;
  logic                       v_outside;
  logic                       hit;

  flappy_edge_sync #(.RISING(1'b1)) u_flap_sync (
    .clk    (dclk),
    .rst    (clr),
    .async_i(game.flap),
    .edge_o (flap_rise)
  );

  flappy_edge_sync #(.RISING(1'b0)) u_vsync_sync (
    .clk    (dclk),
    .rst    (clr),
    .async_i(game.vsync),
    .edge_o (frame_tick)
  );

`ifdef FLAPPY_SPEEDUP_EN
  logic [4:0] bonus;
  assign bonus = (score_q[7:3] > 5'd4) ? 5'd4 : score_q[7:3];
  assign speed = COL_BITS'(PIPE_SPEED) + {{(COL_BITS-5){1'b0}}, bonus};
`else
  assign speed = COL_BITS'(PIPE_SPEED);
`endif

  // Candidate next-frame values; only committed on a tick that runs a PLAY update.
  always_comb begin
    // A flap edge landing in the tick cycle itself still counts for that tick.
    pend_eff = flap_pend_q | flap_rise;
    vel_inc  = vel_q + VEL_GRAV;
    if (pend_eff) begin
      vel_d = VEL_FLAP;
    end else if (vel_inc > VEL_CAP) begin
      vel_d = VEL_CAP;
    end else begin
      vel_d = vel_inc;
    end

    y_sum      = $signed({1'b0, bird_q}) + $signed({{(11-VEL_BITS){vel_d[VEL_BITS-1]}}, vel_d});
    ground_hit = 1'b0;
    if (y_sum[10]) begin
      bird_d = '0;
    end else if (y_sum >= 11'(Y_MAX)) begin
      bird_d     = ROW_BITS'(Y_MAX);
      ground_hit = 1'b1;
    end else begin
      bird_d = y_sum[ROW_BITS-1:0];
    end

    wrap    = pipe_q < speed;
    pipe_d  = wrap ? COL_BITS'(PIPE_START) : pipe_q - speed;
    score_d = (wrap && score_q != 8'hFF) ? score_q + 8'd1 : score_q;

    pipe_ext  = {2'b00, pipe_d};
    bird_ext  = {1'b0, bird_d};
    h_overlap = (pipe_ext < 11'(BIRD_X + BIRD_W)) && ((pipe_ext + 11'(PIPE_W)) > 11'(BIRD_X));
    v_outside = (bird_ext < 11'(GAP_TOP)) || ((bird_ext + 11'(BIRD_H)) > 11'(GAP_BOT));
    hit       = (h_overlap && v_outside) || ground_hit;
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      bird_q      <= ROW_BITS'(BIRD_Y0);
      pipe_q      <= COL_BITS'(PIPE_START);
      score_q     <= '0;
      hold_q      <= '0;
      vel_q       <= '0;
      game_over_q <= 1'b0;
      flap_pend_q <= 1'b0;
    end else begin
      flap_pend_q <= frame_tick ? 1'b0 : pend_eff;
      if (frame_tick) begin
        case (state_q)
          ST_IDLE, ST_PLAY: begin
            if (state_q == ST_PLAY || pend_eff) begin
              vel_q   <= vel_d;
              bird_q  <= bird_d;
              pipe_q  <= pipe_d;
              score_q <= score_d;
              if (hit) begin
                state_q     <= ST_DEAD;
                game_over_q <= 1'b1;
                hold_q      <= 8'(DEAD_HOLD);
              end else begin
                state_q <= ST_PLAY;
              end
            end
          end
          ST_DEAD: begin
            if (hold_q != 8'd0) begin
              hold_q <= hold_q - 8'd1;
            end else if (pend_eff) begin
              state_q     <= ST_IDLE;
              bird_q      <= ROW_BITS'(BIRD_Y0);
              pipe_q      <= COL_BITS'(PIPE_START);
              score_q     <= '0;
              vel_q       <= '0;
              game_over_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign game.bird_coord = bird_q;
  assign game.pipe_pos   = pipe_q;
  assign game.score      = score_q;
  assign game.game_over  = game_over_q;
  assign game.state      = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: per-frame game model checked every cycle plus pinned literals.
module tb_flappy_game_ctrl;

  logic dclk = 1'b0;
  logic clr;
  always #5 dclk = ~dclk;

  flappy_game_ctrl_if gif ();

  flappy_game_ctrl dut (
    .dclk(dclk),
    .clr (clr),
    .game(gif)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Game model in plain integers, advanced once per frame.
  int m_state, m_y, m_vel, m_pipe, m_score, m_go, m_hold;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: loop bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_y = 200; m_vel = 0; m_pipe = 480;
    m_score = 0; m_go = 0;  m_hold = 0;
  endtask

  function automatic int cur_speed();
`ifdef FLAPPY_SPEEDUP_EN
    return 2 + (((m_score / 8) > 4) ? 4 : (m_score / 8));
`else
    return 2;
`endif
  endfunction

  task automatic model_play(input bit pend);
    bit ground;
    bit hit;
    int spd;
    ground = 1'b0;
    m_vel = pend ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
    m_y = m_y + m_vel;
    if (m_y < 0) m_y = 0;
    if (m_y >= 464) begin
      m_y = 464;
      ground = 1'b1;
    end
    spd = cur_speed();
    if (m_pipe < spd) begin
      m_pipe = 480;
      if (m_score < 255) m_score++;
    end else begin
      m_pipe = m_pipe - spd;
    end
    hit = (m_pipe < 116) && (m_pipe + 40 > 100) && (m_y < 160 || m_y + 16 > 300);
    if (hit || ground) begin
      m_state = 2; m_go = 1; m_hold = 60;
    end else begin
      m_state = 1;
    end
  endtask

  task automatic model_tick(input bit pend);
    case (m_state)
      0: if (pend) model_play(1'b1);
      1: model_play(pend);
      default: begin
        if (m_hold > 0) m_hold--;
        else if (pend) model_reset();
      end
    endcase
  endtask

  always @(negedge dclk) begin
    if (chk_en) begin
      check("bird_coord", int'(gif.bird_coord), m_y);
      check("pipe_pos",   int'(gif.pipe_pos),   m_pipe);
      check("score",      int'(gif.score),      m_score);
      check("game_over",  int'(gif.game_over),  m_go);
      check("state",      int'(gif.state),      m_state);
    end
  end

  // One frame: nflaps separate button pulses, then a vsync fall (optionally with a
  // flap rising in the very same cycle); the model steps when the DUT should.
  task automatic frame(input int nflaps, input bit same);
    for (int i = 0; i < nflaps; i++) begin
      @(negedge dclk); gif.flap = 1'b1;
      @(negedge dclk); gif.flap = 1'b0;
      @(negedge dclk);
    end
    @(negedge dclk);
    gif.vsync = 1'b0;
    if (same) gif.flap = 1'b1;
    repeat (3) @(posedge dclk);
    model_tick(nflaps > 0 || same);
    @(negedge dclk);
    gif.flap  = 1'b0;
    gif.vsync = 1'b1;
    repeat (3) @(negedge dclk);
    $display("frame flaps=%0d same=%0d -> state=%0d bird=%0d pipe=%0d score=%0d",
             nflaps, same, gif.state, gif.bird_coord, gif.pipe_pos, gif.score);
  endtask

  initial begin
    int n;
    gif.flap  = 1'b0;
    gif.vsync = 1'b1;
    clr       = 1'b1;
    model_reset();
    repeat (3) @(negedge dclk);
    chk_en = 1'b1;
    check("reset_bird", int'(gif.bird_coord), 200);
    check("reset_pipe", int'(gif.pipe_pos), 480);
    check("reset_state", int'(gif.state), 0);
    clr = 1'b0;
    repeat (3) @(negedge dclk);

    // IDLE ignores ticks without a flap
    frame(0, 1'b0);
    check("idle_hold_state", int'(gif.state), 0);

    // start and first free-fall frames
    frame(1, 1'b0);
    check("start_state", int'(gif.state), 1);
    check("start_bird", int'(gif.bird_coord), 192);
    check("start_pipe", int'(gif.pipe_pos), 478);
    frame(0, 1'b0);
    check("fall1_bird", int'(gif.bird_coord), 185);
    check("fall1_pipe", int'(gif.pipe_pos), 476);
    frame(0, 1'b0);
    check("fall2_bird", int'(gif.bird_coord), 179);
    check("fall2_pipe", int'(gif.pipe_pos), 474);

    // asynchronous reset between clock edges
    @(negedge dclk);
    #2 clr = 1'b1;
    #1;
    check("async_rst_bird", int'(gif.bird_coord), 200);
    check("async_rst_pipe", int'(gif.pipe_pos), 480);
    check("async_rst_state", int'(gif.state), 0);
    check("async_rst_go", int'(gif.game_over), 0);
    model_reset();
    @(negedge dclk); clr = 1'b0;
    repeat (2) @(negedge dclk);

    // three flaps between ticks act as one
    frame(3, 1'b0);
    check("multi_flap_bird", int'(gif.bird_coord), 192);
    frame(0, 1'b0);
    // flap edge in the tick cycle applies to that tick: 185 - 8
    frame(0, 1'b1);
    check("same_cycle_flap_bird", int'(gif.bird_coord), 177);

    // ceiling clamp is not fatal
    repeat (25) frame(1, 1'b0);
    check("ceiling_bird", int'(gif.bird_coord), 0);
    check("ceiling_state", int'(gif.state), 1);

    // ground death
    n = 0;
    while (m_state == 1 && n < 150) begin frame(0, 1'b0); n++; end
    if (n >= 150) timeout_fail("ground_wait");
    check("ground_bird", int'(gif.bird_coord), 464);
    check("ground_state", int'(gif.state), 2);
    check("ground_go", int'(gif.game_over), 1);

    // DEAD: outputs frozen, early flaps ignored
    frame(0, 1'b0);
    frame(1, 1'b0);
    frame(1, 1'b0);
    check("dead_frozen_bird", int'(gif.bird_coord), 464);
    check("dead_early_flap_state", int'(gif.state), 2);
    n = 0;
    while (m_hold > 0 && n < 100) begin frame(0, 1'b0); n++; end
    if (n >= 100) timeout_fail("hold_wait");
    check("hold_done_state", int'(gif.state), 2);
    frame(1, 1'b0);
    check("restart_state", int'(gif.state), 0);
    check("restart_score", int'(gif.score), 0);
    check("restart_bird", int'(gif.bird_coord), 200);

    // pipe collision with the bird held above the gap (~150)
    frame(1, 1'b0);
    n = 0;
    while (m_state == 1 && n < 300) begin frame(m_y >= 150 ? 1 : 0, 1'b0); n++; end
    if (n >= 300) timeout_fail("collide_wait");
    check("collide_state", int'(gif.state), 2);
    check("collide_pipe", int'(gif.pipe_pos), 114);
    n = 0;
    while (m_hold > 0 && n < 100) begin frame(0, 1'b0); n++; end
    if (n >= 100) timeout_fail("hold_wait2");
    frame(1, 1'b0);
    check("restart2_state", int'(gif.state), 0);

    // fly through the gap: wrap and score
    frame(1, 1'b0);
    n = 0;
    while (m_state == 1 && m_score < 1 && n < 300) begin frame(m_y >= 240 ? 1 : 0, 1'b0); n++; end
    if (n >= 300) timeout_fail("wrap_wait");
    check("wrap_pipe", int'(gif.pipe_pos), 480);
    check("wrap_score", int'(gif.score), 1);
    check("wrap_state", int'(gif.state), 1);
    n = 0;
    while (m_state == 1 && m_score < 8 && n < 2500) begin frame(m_y >= 240 ? 1 : 0, 1'b0); n++; end
    if (n >= 2500) timeout_fail("score8_wait");
    check("score8_score", int'(gif.score), 8);
    frame(m_y >= 240 ? 1 : 0, 1'b0);
`ifdef FLAPPY_SPEEDUP_EN
    check("speed_at_8_pipe", int'(gif.pipe_pos), 477);
`else
    check("speed_at_8_pipe", int'(gif.pipe_pos), 478);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
